// File: rtl/local_history_table_if.sv
// Lookup/resolve/update bundle between the local history table and its
// neighbours. The master drives requests; the slave (the table) returns data.
interface local_history_table_if #(
    parameter int PC_IDX_W = 8,
    parameter int HIST_W   = 10,
    parameter int DEPTH    = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Lookup side: a lookup transfers on a cycle where lookup_valid && lookup_ready
    // are both high; history_valid/history_out follow exactly one cycle later.
    // Resolve side has no back-pressure, and update_* is a one-cycle pulse.
    logic                lookup_valid;
    logic [PC_IDX_W-1:0] lookup_pc_idx;
    logic                lookup_ready;
    logic                history_valid;
    logic [HIST_W-1:0]   history_out;
    logic                resolve_valid;
    logic                resolve_taken;
    logic                update_valid;
    logic [HIST_W-1:0]   update_history;
    logic                update_taken;
    logic [CNT_W-1:0]    inflight_count;
    logic                resolve_err;

    modport master (
        output lookup_valid, lookup_pc_idx, resolve_valid, resolve_taken,
        input  lookup_ready, history_valid, history_out,
        input  update_valid, update_history, update_taken,
        input  inflight_count, resolve_err
    );

    modport slave (
        input  lookup_valid, lookup_pc_idx, resolve_valid, resolve_taken,
        output lookup_ready, history_valid, history_out,
        output update_valid, update_history, update_taken,
        output inflight_count, resolve_err
    );
endinterface

// File: rtl/local_history_table.sv
// Per-branch local history table with an in-order in-flight FIFO pairing each
// resolve with its lookup. Define LHT_FLUSH_EN to add the flush input.
module local_history_table #(
    parameter int PC_IDX_W = 8,
    parameter int HIST_W   = 10,
    parameter int DEPTH    = 8
) (
    input  logic clock,
    input  logic reset,
`ifdef LHT_FLUSH_EN
    input  logic flush,
`endif
    local_history_table_if.slave bus
);
    localparam int ENTRIES = 1 << PC_IDX_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    logic [HIST_W-1:0]   r_hist      [ENTRIES];
    logic [PC_IDX_W-1:0] r_fifo_pc   [DEPTH];
    logic [HIST_W-1:0]   r_fifo_snap [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                r_history_valid;
    logic [HIST_W-1:0]   r_history_out;
    logic                r_update_valid;
    logic [HIST_W-1:0]   r_update_history;
    logic                r_update_taken;
    logic                r_resolve_err;

    logic                w_flush;
    logic                w_full;
    logic                w_empty;
    logic                w_lookup_ready;
    logic                w_lookup_fire;
    logic                w_resolve_fire;
    logic                w_resolve_bad;
    logic [PC_IDX_W-1:0] w_head_pc;
    logic [HIST_W-1:0]   w_head_snap;
    logic [HIST_W-1:0]   w_head_next;
    logic [HIST_W-1:0]   w_lookup_hist;

`ifdef LHT_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Ready depends only on occupancy (and flush), never on a same-cycle resolve.
    assign w_lookup_ready = !w_full && !w_flush;
    assign w_lookup_fire  = bus.lookup_valid && w_lookup_ready;
    assign w_resolve_fire = bus.resolve_valid && !w_empty && !w_flush;
    assign w_resolve_bad  = bus.resolve_valid && w_empty && !w_flush;

    assign w_head_pc   = r_fifo_pc[r_rd_ptr];
    assign w_head_snap = r_fifo_snap[r_rd_ptr];
    assign w_head_next = {r_hist[w_head_pc][HIST_W-2:0], bus.resolve_taken};

    // A lookup colliding with a resolving branch sees the shifted-in outcome.
    assign w_lookup_hist = (w_resolve_fire && (w_head_pc == bus.lookup_pc_idx))
                         ? w_head_next
                         : r_hist[bus.lookup_pc_idx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_hist[i] <= '0;
            end
        end else if (w_resolve_fire) begin
            r_hist[w_head_pc] <= w_head_next;
        end
    end

    // Entry storage needs no reset: occupancy is tracked solely by the pointers.
    always_ff @(posedge clock) begin
        if (w_lookup_fire) begin
            r_fifo_pc[r_wr_ptr]   <= bus.lookup_pc_idx;
            r_fifo_snap[r_wr_ptr] <= w_lookup_hist;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_lookup_fire) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_resolve_fire) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_lookup_fire, w_resolve_fire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_history_valid  <= 1'b0;
            r_history_out    <= '0;
            r_update_valid   <= 1'b0;
            r_update_history <= '0;
            r_update_taken   <= 1'b0;
            r_resolve_err    <= 1'b0;
        end else begin
            r_history_valid <= w_lookup_fire;
            if (w_lookup_fire) begin
                r_history_out <= w_lookup_hist;
            end
            r_update_valid <= w_resolve_fire;
            if (w_resolve_fire) begin
                r_update_history <= w_head_snap;
                r_update_taken   <= bus.resolve_taken;
            end
            if (w_resolve_bad) begin
                r_resolve_err <= 1'b1;
            end
        end
    end

    assign bus.lookup_ready   = w_lookup_ready;
    assign bus.history_valid  = r_history_valid;
    assign bus.history_out    = r_history_out;
    assign bus.update_valid   = r_update_valid;
    assign bus.update_history = r_update_history;
    assign bus.update_taken   = r_update_taken;
    assign bus.inflight_count = r_count;
    assign bus.resolve_err    = r_resolve_err;

endmodule

// File: tb/tb_local_history_table.sv
// Self-checking bench for local_history_table: reference model plus expected
// queues, checked by a per-cycle monitor and by directed scenario tasks.
module tb_local_history_table;
    localparam int PC_IDX_W = 8;
    localparam int HIST_W   = 10;
    localparam int DEPTH    = 8;
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int FIFO_W   = PC_IDX_W + HIST_W;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [HIST_W-1:0] hist_exp_q[$];
    logic [HIST_W:0]   upd_exp_q[$];
    logic [FIFO_W-1:0] m_fifo[$];
    logic [HIST_W-1:0] m_hist[1 << PC_IDX_W];
    logic              m_err;

    always #5 clock = ~clock;

    local_history_table_if #(.PC_IDX_W(PC_IDX_W), .HIST_W(HIST_W), .DEPTH(DEPTH)) lif();

    local_history_table #(.PC_IDX_W(PC_IDX_W), .HIST_W(HIST_W), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
`ifdef LHT_FLUSH_EN
        .flush (flush),
`endif
        .bus   (lif)
    );

    // ---------------- monitor: compare every cycle against the model
    always @(posedge clock) begin
        logic [HIST_W-1:0] exp_h;
        logic [HIST_W:0]   exp_u;
        #1;
        if (reset) begin
            checks++;
            if (lif.history_valid !== (hist_exp_q.size() != 0)) begin
                errors++;
                $display("FAIL history_valid: got %b expected %b", lif.history_valid, hist_exp_q.size() != 0);
                hist_exp_q.delete();
            end else if (lif.history_valid) begin
                exp_h = hist_exp_q.pop_front();
                checks++;
                if (lif.history_out !== exp_h) begin
                    errors++;
                    $display("FAIL history_out: got %h expected %h", lif.history_out, exp_h);
                end
            end
            checks++;
            if (lif.update_valid !== (upd_exp_q.size() != 0)) begin
                errors++;
                $display("FAIL update_valid: got %b expected %b", lif.update_valid, upd_exp_q.size() != 0);
                upd_exp_q.delete();
            end else if (lif.update_valid) begin
                exp_u = upd_exp_q.pop_front();
                checks++;
                if ({lif.update_history, lif.update_taken} !== exp_u) begin
                    errors++;
                    $display("FAIL update_pair: got %h/%b expected %h/%b",
                             lif.update_history, lif.update_taken, exp_u[HIST_W:1], exp_u[0]);
                end
            end
            checks++;
            if (lif.inflight_count !== CNT_W'(m_fifo.size())) begin
                errors++;
                $display("FAIL inflight_count: got %0d expected %0d", lif.inflight_count, m_fifo.size());
            end
            checks++;
            if (lif.resolve_err !== m_err) begin
                errors++;
                $display("FAIL resolve_err: got %b expected %b", lif.resolve_err, m_err);
            end
            checks++;
            if (lif.lookup_ready !== ((m_fifo.size() != DEPTH) && !flush)) begin
                errors++;
                $display("FAIL lookup_ready: got %b expected %b", lif.lookup_ready, (m_fifo.size() != DEPTH) && !flush);
            end
        end
    end

    // ---------------- driver: one clock of stimulus plus model update
    task automatic drive(input bit lv, input logic [PC_IDX_W-1:0] lpc,
                         input bit rv, input bit rt, input bit fl);
        bit fl_eff;
        bit acc;
        bit res;
        logic [FIFO_W-1:0]   head;
        logic [PC_IDX_W-1:0] hpc;
`ifdef LHT_FLUSH_EN
        fl_eff = fl;
`else
        fl_eff = 1'b0;
`endif
        lif.lookup_valid  = lv;
        lif.lookup_pc_idx = lpc;
        lif.resolve_valid = rv;
        lif.resolve_taken = rt;
        flush             = fl_eff;
        @(posedge clock);
        acc = lv && !fl_eff && (m_fifo.size() != DEPTH);
        res = rv && !fl_eff && (m_fifo.size() != 0);
        if (rv && !fl_eff && m_fifo.size() == 0) m_err = 1'b1;
        if (res) begin
            head = m_fifo.pop_front();
            hpc  = head[FIFO_W-1:HIST_W];
            m_hist[hpc] = {m_hist[hpc][HIST_W-2:0], rt};
            upd_exp_q.push_back({head[HIST_W-1:0], rt});
        end
        if (acc) begin
            hist_exp_q.push_back(m_hist[lpc]);
            m_fifo.push_back({lpc, m_hist[lpc]});
        end
        if (fl_eff) m_fifo.delete();
        #2;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        lif.lookup_valid  = 1'b0;
        lif.lookup_pc_idx = '0;
        lif.resolve_valid = 1'b0;
        lif.resolve_taken = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < (1 << PC_IDX_W); i++) m_hist[i] = '0;
        m_fifo.delete();
        hist_exp_q.delete();
        upd_exp_q.delete();
        m_err = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        do_reset();
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);   // error resolve
        drive(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);   // history_out = 1, one in flight
        reset = 1'b0;
        #1;
        checks++;
        if ({lif.history_valid, lif.history_out, lif.update_valid, lif.update_history,
             lif.update_taken, lif.resolve_err} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got hv=%b h=%h uv=%b uh=%h ut=%b err=%b expected all 0",
                     lif.history_valid, lif.history_out, lif.update_valid, lif.update_history,
                     lif.update_taken, lif.resolve_err);
        end
        checks++;
        if (lif.inflight_count !== 4'd0 || lif.lookup_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_fifo: got count=%0d ready=%b expected 0/1", lif.inflight_count, lif.lookup_ready);
        end
        do_reset();
        drive(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lif.history_out !== 10'h000) begin
            errors++;
            $display("FAIL reset_clears_table: got %h expected 000", lif.history_out);
        end
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_lookup_resolve();
        do_reset();
        drive(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lif.history_valid !== 1'b1 || lif.history_out !== 10'h000 || lif.inflight_count !== 4'd1) begin
            errors++;
            $display("FAIL first_lookup: got hv=%b h=%h cnt=%0d expected 1/000/1",
                     lif.history_valid, lif.history_out, lif.inflight_count);
        end
        drive(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (lif.update_valid !== 1'b1 || lif.update_history !== 10'h000 || lif.update_taken !== 1'b1) begin
            errors++;
            $display("FAIL first_update: got uv=%b uh=%h ut=%b expected 1/000/1",
                     lif.update_valid, lif.update_history, lif.update_taken);
        end
        drive(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lif.history_out !== 10'h001) begin
            errors++;
            $display("FAIL second_lookup: got %h expected 001", lif.history_out);
        end
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_pattern();
        logic [3:0] pat;
        pat = 4'b1011;  // applied MSB first: 1,0,1,1
        do_reset();
        for (int i = 3; i >= 0; i--) begin
            drive(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 8'd0, 1'b1, pat[i], 1'b0);
        end
        checks++;
        if (lif.update_history !== 10'h005 || lif.update_taken !== 1'b1) begin
            errors++;
            $display("FAIL pattern_last_update: got %h/%b expected 005/1", lif.update_history, lif.update_taken);
        end
        drive(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lif.history_out !== 10'h00B) begin
            errors++;
            $display("FAIL pattern_final_hist: got %h expected 00b", lif.history_out);
        end
        drive(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);   // non-speculative: same value again
        checks++;
        if (lif.history_out !== 10'h00B) begin
            errors++;
            $display("FAIL back_to_back_same_pc: got %h expected 00b", lif.history_out);
        end
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, PC_IDX_W'(i * 3), 1'b0, 1'b0, 1'b0);
        checks++;
        if (lif.inflight_count !== 4'd8 || lif.lookup_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state: got cnt=%0d ready=%b expected 8/0", lif.inflight_count, lif.lookup_ready);
        end
        drive(1'b1, 8'd77, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lif.history_valid !== 1'b0 || lif.inflight_count !== 4'd8) begin
            errors++;
            $display("FAIL ninth_lookup: got hv=%b cnt=%0d expected 0/8", lif.history_valid, lif.inflight_count);
        end
        drive(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 8'd20, 1'b1, 1'b0, 1'b0);
        checks++;
        if (lif.inflight_count !== 4'd7 || lif.history_valid !== 1'b1 || lif.update_valid !== 1'b1) begin
            errors++;
            $display("FAIL push_pop_same_cycle: got cnt=%0d hv=%b uv=%b expected 7/1/1",
                     lif.inflight_count, lif.history_valid, lif.update_valid);
        end
        for (int i = 0; i < 7; i++) drive(1'b0, 8'd0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic test_resolve_err();
        do_reset();
        drive(1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);   // empty FIFO
        checks++;
        if (lif.resolve_err !== 1'b1 || lif.update_valid !== 1'b0 || lif.inflight_count !== 4'd0) begin
            errors++;
            $display("FAIL empty_resolve: got err=%b uv=%b cnt=%0d expected 1/0/0",
                     lif.resolve_err, lif.update_valid, lif.inflight_count);
        end
        repeat (3) idle();
        drive(1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lif.resolve_err !== 1'b1 || lif.history_out !== 10'h001) begin
            errors++;
            $display("FAIL err_sticky_table_kept: got err=%b h=%h expected 1/001", lif.resolve_err, lif.history_out);
        end
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_bypass();
        do_reset();
        drive(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);   // hist[3] = 0x002
        drive(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'd3, 1'b1, 1'b1, 1'b0);
        checks++;
        if (lif.history_out !== 10'h005 || lif.update_history !== 10'h002) begin
            errors++;
            $display("FAIL same_cycle_bypass: got h=%h uh=%h expected 005/002", lif.history_out, lif.update_history);
        end
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (lif.update_history !== 10'h005) begin
            errors++;
            $display("FAIL bypass_snapshot: got %h expected 005", lif.update_history);
        end
    endtask

`ifdef LHT_FLUSH_EN
    task automatic test_flush();
        do_reset();
        drive(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, PC_IDX_W'(i + 10), 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        checks++;
        if (lif.lookup_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_during_flush: got %b expected 0", lif.lookup_ready);
        end
        drive(1'b1, 8'd7, 1'b1, 1'b1, 1'b1);
        checks++;
        if (lif.inflight_count !== 4'd0 || lif.history_valid !== 1'b0 || lif.update_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empties: got cnt=%0d hv=%b uv=%b expected 0/0/0",
                     lif.inflight_count, lif.history_valid, lif.update_valid);
        end
        drive(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (lif.resolve_err !== 1'b1) begin
            errors++;
            $display("FAIL resolve_after_flush: got err=%b expected 1", lif.resolve_err);
        end
        drive(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lif.history_out !== 10'h001) begin
            errors++;
            $display("FAIL flush_keeps_table: got %h expected 001", lif.history_out);
        end
        drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_random();
        bit fl;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            fl = ($urandom_range(0, 39) == 0);
            drive(1'($urandom_range(0, 2) != 0), PC_IDX_W'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), fl);
        end
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 8'd0, 1'(m_fifo.size() != 0), 1'b1, 1'b0);
    endtask

    initial begin
        #3;
        test_reset();
        test_lookup_resolve();
        test_pattern();
        test_full();
        test_resolve_err();
        test_bypass();
`ifdef LHT_FLUSH_EN
        test_flush();
`endif
        test_random();
        idle();
        checks++;
        if (hist_exp_q.size() != 0 || upd_exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d/%0d pending expected 0/0", hist_exp_q.size(), upd_exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/local_history_table.md
Name: local_history_table

Overview:
- Per-branch local history store. It sits upstream of the local pattern predictor in the tournament predictor.
- On lookup, it supplies the 10-bit local history that the pattern predictor uses as its table index.
- On branch resolution, it sends the pattern predictor the update pair (history index used at lookup, actual outcome), then shifts the outcome into that branch's history.
- An in-order in-flight FIFO pairs each resolution with its lookup.

Parameters:
- PC_IDX_W, 8, width of the branch PC index; the table has 2**PC_IDX_W entries.
- HIST_W, 10, local history length in bits; matches the pattern predictor index width.
- DEPTH, 8, maximum number of in-flight lookups awaiting resolution (power of 2).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- lookup_valid  input  1  lookup request this cycle.
- lookup_pc_idx  input  PC_IDX_W  branch PC index for the lookup.
- lookup_ready  output  1  lookup can be accepted.
- history_valid  output  1  history_out is valid (one cycle after the lookup is accepted).
- history_out  output  HIST_W  local history for the accepted lookup; goes to the pattern predictor historyTable input.
- resolve_valid  input  1  oldest in-flight branch resolves this cycle.
- resolve_taken  input  1  actual outcome of the resolving branch.
- update_valid  output  1  update pulse to the pattern predictor.
- update_history  output  HIST_W  history snapshot captured at lookup for the resolved branch.
- update_taken  output  1  actual outcome; goes to the pattern predictor taken input.
- inflight_count  output  $clog2(DEPTH)+1  number of occupied FIFO entries.
- resolve_err  output  1  sticky flag: a resolve arrived with the FIFO empty.

Behaviour:
- Reset (asynchronous, reset=0):
  - All history entries = 0.
  - FIFO pointers = 0, inflight_count = 0.
  - history_valid = 0, history_out = 0.
  - update_valid = 0, update_history = 0, update_taken = 0.
  - resolve_err = 0.
  - Reset mid-operation discards all in-flight entries.
- lookup_ready = (inflight_count != DEPTH). It is combinational from the count only and does not depend on a same-cycle resolve.
- Lookup is accepted when lookup_valid && lookup_ready. Next cycle:
  - history_valid = 1.
  - history_out = hist[lookup_pc_idx].
  - The FIFO receives {lookup_pc_idx, that same history value}.
  - When no lookup is accepted, history_valid = 0 and history_out holds its value.
- Same-cycle bypass: if a resolve updates the same PC index in the cycle a lookup is accepted, history_out and the FIFO snapshot use the post-update history.
- Resolve:
  - resolve_valid with inflight_count > 0 pops the FIFO head {pc, snap}.
  - Same edge: hist[pc] <= {hist[pc][HIST_W-2:0], resolve_taken}; the newest outcome goes into the LSB.
  - Next cycle: update_valid = 1, update_history = snap, update_taken = resolve_taken.
  - Otherwise update_valid = 0.
- Resolve with an empty FIFO: ignored (no table or pointer change, update_valid = 0). resolve_err is set and stays set until reset.
- Simultaneous accepted lookup and valid resolve: push and pop occur together, so inflight_count is unchanged.
  - When inflight_count = 0, the resolve is an error as above.
  - The resolve cannot pop the entry pushed in the same cycle.
- History is non-speculative: back-to-back lookups of the same PC before resolution return identical histories.
- FIFO pointers wrap modulo DEPTH. inflight_count saturates at DEPTH only through lookup_ready gating.

Optional Feature:
- Macro LHT_FLUSH_EN.
- When defined: adds input port flush (1 bit). flush=1 empties the FIFO (pointers and count to 0) on the next edge. The history table is retained.
- Flush has priority over any same-cycle lookup and resolve: neither is accepted or applied, and update_valid and history_valid are 0 the next cycle. lookup_ready = 0 while flush = 1.
- When not defined: no flush port. The FIFO drains only through resolves.

Test Plan:
- Reset, then lookup pc=5 -> next cycle history_valid=1, history_out=0x000, inflight_count=1.
- Resolve taken=1 for pc=5 -> next cycle update_valid=1, update_history=0x000, update_taken=1. A new lookup of pc=5 returns 0x001.
- Resolve pc=5 with taken pattern 1,0,1,1 (each lookup followed by a resolve) -> final hist[5]=0x00B. The last update_history is 0x005.
- 8 lookups without resolves -> lookup_ready=0, and a 9th lookup_valid is not accepted. A simultaneous resolve plus lookup with count=7 -> count stays 7.
- Resolve with inflight_count=0 -> resolve_err=1 persists, update_valid=0, table unchanged.
- Same-cycle resolve (taken=1) of pc=3 with hist=0x002 and lookup of pc=3 -> history_out=0x005.
- With LHT_FLUSH_EN: 3 lookups, then flush -> inflight_count=0. A following resolve sets resolve_err=1.
